// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- single-outstanding-request instruction fetch unit.
//
// Fetches one word at a time from instruction memory and hands the result to
// the IF/ID boundary through a one-entry valid/ready buffer. A redirect from
// EX either replaces the PC immediately (when no request is in flight) or is
// parked in redirect_pc with the squash flag set, so that the in-flight
// response is dropped when it finally arrives.
//
// Parameters:
//   RESET_PC        PC loaded while rst is low.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             asynchronous active-low reset
//   redirect_valid  EX requests a PC change this cycle
//   pcmux_sel       target select: pc_plus4 (no redirect), alu_out, alu_mod2
//   alu_out         branch/jump target from EX
//   imem_read       instruction memory read request (FETCH only)
//   imem_address    word-aligned fetch address, stable until imem_resp
//   imem_resp       one-cycle read completion pulse
//   imem_rdata      instruction data, valid with imem_resp
//   if_valid        buffered instruction offered to IF/ID
//   if_pc           PC of offered instruction
//   if_instr        offered instruction
//   id_ready        IF/ID accepts the offer this cycle
//
// Optional build macro:
//   FETCH_STATS_EN  adds 32-bit wrapping counters stat_fetched,
//                   stat_squashed and stat_stall as extra outputs.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h40000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [1:0]  pcmux_sel,
    input  logic [31:0] alu_out,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_squashed,
    output logic [31:0] stat_stall
`endif
);

    // pcmux_sel_t encodings: pc_plus4 = 0, alu_out = 1, alu_mod2 = 2.
    // 2'b11 is unencoded and behaves like pc_plus4 (no redirect).
    typedef enum logic [1:0] {
        SEL_PC_PLUS4 = 2'b00,
        SEL_ALU_OUT  = 2'b01,
        SEL_ALU_MOD2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        squash, squash_next;
    logic [31:0] redirect_pc, redirect_pc_next;
    logic [31:0] if_pc_next, if_instr_next;

    logic        redirect;
    logic [31:0] target;

    // Only the two target-selecting encodings count as a real redirect.
    always_comb begin
        redirect = 1'b0;
        target   = alu_out;
        if (redirect_valid) begin
            if (pcmux_sel == SEL_ALU_OUT) begin
                redirect = 1'b1;
            end else if (pcmux_sel == SEL_ALU_MOD2) begin
                redirect = 1'b1;
                target   = {alu_out[31:1], 1'b0};
            end
        end
    end

    // The address is always derived from pc; pc only changes on a response
    // or outside FETCH, which keeps the request stable until imem_resp.
    assign imem_address = {pc[31:2], 2'b00};

    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        squash_next      = squash;
        redirect_pc_next = redirect_pc;
        if_pc_next       = if_pc;
        if_instr_next    = if_instr;
        imem_read        = 1'b0;
        if_valid         = 1'b0;

        unique case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                imem_read = 1'b1;
                if (imem_resp) begin
                    if (redirect) begin
                        // A live redirect beats any parked one; the
                        // response belongs to the wrong path either way.
                        pc_next     = target;
                        squash_next = 1'b0;
                    end else if (squash) begin
                        pc_next     = redirect_pc;
                        squash_next = 1'b0;
                    end else begin
                        if_pc_next    = pc;
                        if_instr_next = imem_rdata;
                        state_next    = HOLD;
                    end
                end else if (redirect) begin
                    // The request stays in flight; remember where to go once
                    // its response has been thrown away. Latest one wins.
                    redirect_pc_next = target;
                    squash_next      = 1'b1;
                end
            end

            HOLD: begin
                if_valid = 1'b1;
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (id_ready) begin
                    pc_next    = if_pc + 32'd4;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // NOTE: all state, including the redirect_pc and output buffers, is reset
    // so nothing observable is X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            redirect_pc <= 32'h0;
            if_pc       <= 32'h0;
            if_instr    <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            squash      <= squash_next;
            redirect_pc <= redirect_pc_next;
            if_pc       <= if_pc_next;
            if_instr    <= if_instr_next;
        end
    end

`ifdef FETCH_STATS_EN
    logic fetch_accept;
    logic resp_discard;
    logic hold_stall;

    // A redirect in HOLD drops the buffered word, so it is not an acceptance.
    assign fetch_accept = (state == HOLD) && id_ready && !redirect;
    assign resp_discard = (state == FETCH) && imem_resp && (redirect || squash);
    assign hold_stall   = (state == HOLD) && !id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched  <= 32'h0;
            stat_squashed <= 32'h0;
            stat_stall    <= 32'h0;
        end else begin
            if (fetch_accept) stat_fetched  <= stat_fetched + 32'd1;
            if (resp_discard) stat_squashed <= stat_squashed + 32'd1;
            if (hold_stall)   stat_stall    <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Memory data is produced by instr_at() so each address has a known word.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  pcmux_sel;
    logic [31:0] alu_out;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_squashed;
    logic [31:0] stat_stall;
`endif

    int total;
    int bad;

    fetch_stage #(.RESET_PC(32'h40000060)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .pcmux_sel      (pcmux_sel),
        .alu_out        (alu_out),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_squashed  (stat_squashed),
        .stat_stall     (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h00000013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redirect(input logic v, input logic [1:0] sel, input logic [31:0] tgt);
        redirect_valid = v;
        pcmux_sel      = sel;
        alu_out        = tgt;
    endtask

    task automatic set_resp(input logic v, input logic [31:0] d);
        imem_resp  = v;
        imem_rdata = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        id_ready = 1'b0;
        set_redirect(1'b0, 2'b00, 32'h0);
        set_resp(1'b0, 32'h0);

        // Reset state.
        tick();
        tick();
        check("rst_read",     {31'h0, imem_read}, 32'h0);
        check("rst_valid",    {31'h0, if_valid},  32'h0);
        check("rst_if_pc",    if_pc,              32'h0);
        check("rst_if_instr", if_instr,           32'h0);

        // Release: IDLE -> FETCH on the first clock.
        rst = 1'b1;
        tick();
        check("f0_read", {31'h0, imem_read}, 32'h1);
        check("f0_addr", imem_address,       32'h40000060);

        // Memory answers on the second FETCH cycle.
        tick();
        check("f0_addr_held", imem_address, 32'h40000060);
        check("f0_valid_lo",  {31'h0, if_valid}, 32'h0);
        set_resp(1'b1, instr_at(32'h40000060));
        tick();
        check("h0_valid", {31'h0, if_valid}, 32'h1);
        check("h0_pc",    if_pc,             32'h40000060);
        check("h0_instr", if_instr,          instr_at(32'h40000060));
        check("h0_read",  {31'h0, imem_read}, 32'h0);

        // Accept, then zero-wait response.
        set_resp(1'b0, 32'h0);
        id_ready = 1'b1;
        tick();
        check("f1_addr",  imem_address,       32'h40000064);
        check("f1_valid", {31'h0, if_valid},  32'h0);
        id_ready = 1'b0;
        set_resp(1'b1, instr_at(32'h40000064));
        tick();
        check("h1_pc",    if_pc,             32'h40000064);
        check("h1_valid", {31'h0, if_valid}, 32'h1);

        // Stall 5 cycles in HOLD; stray responses must be ignored.
        for (int i = 0; i < 5; i++) begin
            set_resp(1'b1, 32'hDEADBEEF);
            tick();
            check("stall_valid", {31'h0, if_valid},  32'h1);
            check("stall_pc",    if_pc,              32'h40000064);
            check("stall_instr", if_instr,           instr_at(32'h40000064));
            check("stall_read",  {31'h0, imem_read}, 32'h0);
        end
`ifdef FETCH_STATS_EN
        check("stat_stall5", stat_stall, 32'd5);
`endif
        set_resp(1'b0, 32'h0);
        id_ready = 1'b1;
        tick();
        check("f2_addr", imem_address, 32'h40000068);
        id_ready = 1'b0;

        // alu_mod2 redirect while a fetch is outstanding.
        set_redirect(1'b1, 2'b10, 32'h40000123);
        tick();
        check("sq_addr_held", imem_address, 32'h40000068);
        set_redirect(1'b0, 2'b00, 32'h0);
        set_resp(1'b1, 32'hBAD0BAD0);
        tick();
        check("sq_addr",  imem_address,      32'h40000120);
        check("sq_valid", {31'h0, if_valid}, 32'h0);
        set_resp(1'b1, instr_at(32'h40000120));
        tick();
        check("sq_if_pc",    if_pc,    32'h40000122);
        check("sq_if_instr", if_instr, instr_at(32'h40000120));
        set_resp(1'b0, 32'h0);
        id_ready = 1'b1;
        tick();
        check("sq_next_addr", imem_address, 32'h40000124);
        id_ready = 1'b0;

        // Redirect coinciding with a response, then two parked redirects and
        // two non-redirect selects while squash is set.
        set_redirect(1'b1, 2'b01, 32'h40000200);
        set_resp(1'b1, 32'hBAD1BAD1);
        tick();
        check("co_addr",  imem_address,      32'h40000200);
        check("co_valid", {31'h0, if_valid}, 32'h0);
        set_resp(1'b0, 32'h0);
        set_redirect(1'b1, 2'b01, 32'h40000300);
        tick();
        set_redirect(1'b1, 2'b10, 32'h40000401);
        tick();
        set_redirect(1'b1, 2'b00, 32'h40000900);
        tick();
        set_redirect(1'b1, 2'b11, 32'h40000a00);
        tick();
        check("co_addr_held", imem_address,      32'h40000200);
        check("co_valid_lo",  {31'h0, if_valid}, 32'h0);
        set_redirect(1'b0, 2'b00, 32'h0);
        set_resp(1'b1, 32'hBAD2BAD2);
        tick();
        check("late_addr",  imem_address,      32'h40000400);
        check("late_valid", {31'h0, if_valid}, 32'h0);
        set_resp(1'b1, instr_at(32'h40000400));
        tick();
        check("late_if_pc", if_pc, 32'h40000400);
        set_resp(1'b0, 32'h0);

        // Redirect in HOLD without id_ready drops the offer; then wrap.
        set_redirect(1'b1, 2'b01, 32'hFFFFFFFC);
        tick();
        check("hr_valid", {31'h0, if_valid}, 32'h0);
        check("hr_addr",  imem_address,      32'hFFFFFFFC);
        set_redirect(1'b0, 2'b00, 32'h0);
        set_resp(1'b1, instr_at(32'hFFFFFFFC));
        tick();
        check("wrap_if_pc", if_pc, 32'hFFFFFFFC);
        set_resp(1'b0, 32'h0);
        id_ready = 1'b1;
        tick();
        check("wrap_addr", imem_address,       32'h00000000);
        check("wrap_read", {31'h0, imem_read}, 32'h1);
        id_ready = 1'b0;
`ifdef FETCH_STATS_EN
        check("stat_fetched",  stat_fetched,  32'd4);
        check("stat_squashed", stat_squashed, 32'd3);
        check("stat_stall6",   stat_stall,    32'd6);
`endif

        // Reset mid-FETCH, late response lands in IDLE.
        rst = 1'b0;
        #1;
        check("mr_read",  {31'h0, imem_read}, 32'h0);
        check("mr_valid", {31'h0, if_valid},  32'h0);
        tick();
        tick();
        rst = 1'b1;
        set_resp(1'b1, 32'hBAD3BAD3);
        tick();
        set_resp(1'b0, 32'h0);
        check("mr_valid_idle", {31'h0, if_valid},  32'h0);
        check("mr_read2",      {31'h0, imem_read}, 32'h1);
        check("mr_addr",       imem_address,       32'h40000060);
`ifdef FETCH_STATS_EN
        check("mr_stat_fetched", stat_fetched, 32'd0);
`endif
        tick();
        check("mr_valid2",    {31'h0, if_valid}, 32'h0);
        check("mr_addr_held", imem_address,      32'h40000060);
        set_resp(1'b1, instr_at(32'h40000060));
        tick();
        set_resp(1'b0, 32'h0);
        check("mr_if_valid", {31'h0, if_valid}, 32'h1);
        check("mr_if_pc",    if_pc,             32'h40000060);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h40000060, PC loaded at reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port redirect_valid  input  1  EX stage requests PC change this cycle.
REQ-005 SHALL have port pcmux_sel  input  2  pcmux_sel_t: pc_plus4, alu_out or alu_mod2.
REQ-006 SHALL have port alu_out  input  32  branch/jump target from EX.
REQ-007 SHALL have port imem_read  output  1  instruction memory read request.
REQ-008 SHALL have port imem_address  output  32  word-aligned fetch address.
REQ-009 SHALL have port imem_resp  input  1  one-cycle read completion pulse.
REQ-010 SHALL have port imem_rdata  input  32  instruction data, valid with imem_resp.
REQ-011 SHALL have port if_valid  output  1  buffered instruction offered to IF/ID.
REQ-012 SHALL have port if_pc  output  32  PC of offered instruction.
REQ-013 SHALL have port if_instr  output  32  offered instruction.
REQ-014 SHALL have port id_ready  input  1  IF/ID accepts offer this cycle.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD plus a squash flag and a 32-bit redirect_pc register.
REQ-016 SHALL compute target = alu_out for alu_out and {alu_out[31:1],1'b0} for alu_mod2.
REQ-017 SHALL treat redirect_valid with pcmux_sel = pc_plus4 or an unencoded value (2'b11) as no redirect.
REQ-018 SHALL drive imem_read = 1 only in FETCH, with imem_address = {pc[31:2],2'b00} held stable until imem_resp.
REQ-019 SHALL move IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-020 SHALL, in FETCH on imem_resp with no squash and no redirect, capture if_pc = pc and if_instr = imem_rdata and enter HOLD.
REQ-021 SHALL, in FETCH on redirect without imem_resp, store the target in redirect_pc and set squash; the outstanding request is not cancelled.
REQ-022 SHALL, in FETCH on imem_resp with squash set, discard the data, load pc = redirect_pc, clear squash and remain in FETCH.
REQ-023 SHALL, in FETCH on imem_resp with a simultaneous redirect, discard the data, load pc = target and remain in FETCH; this redirect takes priority over any pending redirect_pc.
REQ-024 SHALL overwrite redirect_pc on a further redirect while squash is set (latest redirect wins).
REQ-025 SHALL assert if_valid only in HOLD; if_pc and if_instr SHALL stay stable while if_valid = 1 and id_ready = 0.
REQ-026 SHALL, in HOLD with id_ready = 1 and no redirect, load pc = if_pc + 4 (mod 2^32) and enter FETCH.
REQ-027 SHALL, in HOLD with redirect (whether or not id_ready = 1), drop the buffered instruction, deassert if_valid next cycle, load pc = target and enter FETCH.
REQ-028 SHALL sustain a peak throughput of one instruction per two cycles with zero-wait memory; a response produces if_valid on the following cycle.
REQ-029 SHALL ignore imem_resp outside FETCH.

Reset
REQ-030 SHALL, while rst = 0, asynchronously force state = IDLE, pc = RESET_PC, squash = 0, redirect_pc = 0, imem_read = 0, if_valid = 0, if_pc = 0, if_instr = 0.
REQ-031 SHALL abandon any outstanding fetch on reset assertion mid-operation; a late imem_resp arriving in IDLE is ignored.

Configuration
REQ-032 SHALL, with FETCH_STATS_EN defined, add outputs stat_fetched, stat_squashed and stat_stall, each 32 bits, reset to 0, wrapping at 2^32.
REQ-033 SHALL increment stat_fetched on each HOLD -> FETCH acceptance and stat_squashed on each discarded imem_resp.
REQ-034 SHALL increment stat_stall on each cycle in HOLD with id_ready = 0.
REQ-035 SHALL, without FETCH_STATS_EN, omit the stat ports and counters with no other behavioural change.

Verification
REQ-036 Release reset, memory responds on the second FETCH cycle, id_ready = 1 -> addresses 40000060 and 40000064 are fetched in order, and if_valid pulses with the matching if_pc.
REQ-037 In HOLD with id_ready = 0 for 5 cycles -> if_pc and if_instr are unchanged, imem_read = 0, and stat_stall = 5 when FETCH_STATS_EN is defined.
REQ-038 Redirect with alu_mod2 and alu_out = 32'h40000123 while a fetch is outstanding -> the response is discarded, the next imem_address is 40000120, and if_pc is 40000122.
REQ-039 Redirect coinciding with imem_resp, plus a second redirect while squash is set -> the data is never offered, and only the latest target is fetched.
REQ-040 pc = 32'hFFFFFFFC accepted -> the next fetch address is 00000000.
REQ-041 rst asserted mid-FETCH, then imem_resp arrives during IDLE -> no if_valid, and the fetch restarts at RESET_PC.
